snn_sideadd_sched: RTL and testbench
====================================

Name: snn_sideadd_sched

Overview:
- Time-multiplexed scheduler that shares one N-input Hamming-sum (sideways-adder) datapath among N_REQ stochastic-neuron requesters.
- Over a window of STREAM_LEN rounds, each requester's N_INPUTS-bit stochastic slice is popcounted once per round. The result is accumulated into a per-requester counter.
- At window end, all counts are published with a DONE pulse. Sits between the synapse bitstream generators and the neuron activation/threshold stage.

Parameters:
- N_INPUTS, 8, bits per requester slice (adder width)
- N_REQ, 4, number of requesters sharing the adder
- STREAM_LEN, 256, rounds per window (bitstream length)
- NB_SUM, clog2(N_INPUTS+1) = 4, popcount width
- NB_ACC, clog2(N_INPUTS*STREAM_LEN+1) = 12, accumulator width; overflow is impossible by construction

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-high
- START  in  1  begin window; honoured only in IDLE
- ABORT  in  1  cancel window; returns to IDLE
- VALID  in  N_REQ  requester slice present
- IN_BUS  in  N_REQ*N_INPUTS  slices; requester r at [r*N_INPUTS +: N_INPUTS]
- ACK  out  N_REQ  slice consumed this cycle (combinational)
- BUSY  out  1  high in RUN/DRAIN
- DONE  out  1  one-cycle pulse; SUM_OUT newly valid
- SUM_OUT  out  N_REQ*NB_ACC  per-requester window counts, same packing as IN_BUS

Behaviour:
- Reset values (RST high, asynchronous):
  - state=IDLE, slot=0, round=0
  - all ACC=0, SUM_OUT=0
  - pipeline valid P_V=0
  - DONE=0, BUSY=0
  - ACK is 0 because state is IDLE.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - START=1 and ABORT=0 → clear all ACC, slot=0, round=0, go to RUN.
  - ABORT dominates START.
- RUN, consume rule:
  - ACK[slot] = VALID[slot]. All other ACK bits are 0.
  - Adder EN = VALID[slot].
  - On consume: P_REG ← popcount(slice[slot]), P_SLOT ← slot, P_V ← 1.
- RUN, stall:
  - VALID[slot]=0 → slot and round hold, no ACK, P_V ← 0.
  - Fixed TDM order; no skipping.
- RUN, advance:
  - After a consume, slot increments.
  - When slot=N_REQ-1 it wraps to 0 and round increments.
  - A consume with slot=N_REQ-1 and round=STREAM_LEN-1 → go to DRAIN (round/slot wrap to 0).
- Accumulate stage (any state except IDLE):
  - When P_V=1: ACC[P_SLOT] ← ACC[P_SLOT] + zero-extended P_REG.
  - This is one cycle after the consume.
- DRAIN:
  - Last accumulate occurs; P_V ← 0; go to FIN.
- FIN:
  - SUM_OUT ← all ACC (registered). DONE is registered high for exactly this cycle.
  - Return to IDLE. START in FIN is ignored.
- SUM_OUT holds until the next completed window. It is not cleared by START or ABORT, only by RST.
- Latency: with no stalls, START sampled at edge t → DONE high in cycle t+N_REQ*STREAM_LEN+2. Each stall cycle adds 1.
- ABORT in RUN/DRAIN/FIN:
  - Go to IDLE next edge and clear P_V; the in-flight popcount is discarded.
  - No DONE; SUM_OUT unchanged; ACK is 0 in the ABORT cycle.
- START while BUSY: ignored, no effect.
- Width rules: all sums are unsigned; no saturation logic required.

Decomposition:
- Shared package:
  - clog2 function
  - FSM state encoding constants (IDLE/RUN/DRAIN/FIN)
  - derived width constants NB_SUM, NB_ACC
- Sub-module: the team's existing N-input sideways-adder module (EN/IN/OUT interface).
  - Instantiate once, with N_inputs=N_INPUTS and NB_out=NB_SUM.
  - EN driven by the consume strobe; IN driven by the slot-muxed slice.
- The slice mux, counters, FSM and accumulator bank live in this block.

Test Plan:
- Params N_INPUTS=4, N_REQ=2, STREAM_LEN=4. Slice0=4'b1111 and slice1=4'b0101 always valid; START at cycle 0 → DONE high at cycle 10, SUM_OUT[0]=16, SUM_OUT[1]=8, ACK alternates 01/10.
- Same setup, VALID[1] low for 3 cycles during round 1 → DONE at cycle 13, sums unchanged (16, 8), no ACK[0] during the stall.
- ABORT asserted at cycle 5 → no DONE, SUM_OUT keeps its prior value, BUSY=0 at cycle 6. A following START yields a full, correct window.
- START held high through a whole window → only one window runs. DONE pulses once; a restart requires START sampled in IDLE after FIN.
- RST asserted mid-RUN (asynchronous, between edges) → all outputs 0 immediately, state IDLE. A subsequent START window gives correct counts.
- Defaults, all slices 8'hFF for the full window → SUM_OUT each = 2048 (max NB_ACC value, no wrap).

Source files
------------

// File: rtl/snn_sideadd_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_sideadd_sched_pkg
//  Description : Shared helpers for the sideways-adder scheduler: ceil-log2,
//                FSM state encoding and default derived widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_sideadd_sched_pkg;

  // Number of bits needed to count values 0 .. value-1 (ceil(log2(value))).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int DEF_N_INPUTS   = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_STREAM_LEN = 256;
  localparam int DEF_NB_SUM     = clog2(DEF_N_INPUTS + 1);
  localparam int DEF_NB_ACC     = clog2(DEF_N_INPUTS * DEF_STREAM_LEN + 1);

endpackage
`default_nettype wire

// File: rtl/snn_sideadd_sched_adder.sv
`default_nettype none
// ============================================================================
//  Module      : snn_sideadd_sched_adder
//  Description : N-input sideways adder (Hamming weight) with enable; output
//                is forced to zero while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_sideadd_sched_adder #(
  parameter int N_INPUTS = 8,
  parameter int NB_OUT   = 4
) (
  input  logic                en_i,
  input  logic [N_INPUTS-1:0] in_i,
  output logic [NB_OUT-1:0]   out_o
);

  // Count the ones in the slice when enabled.
  always_comb begin
    out_o = '0;
    if (en_i) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        out_o = out_o + NB_OUT'(in_i[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_sideadd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : snn_sideadd_sched
//  Description : Time-multiplexes one sideways adder across N_REQ requesters
//                in fixed round-robin order for STREAM_LEN rounds, accumulates
//                per-requester counts and publishes them with a DONE pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_sideadd_sched
  import snn_sideadd_sched_pkg::*;
#(
  parameter int N_INPUTS   = DEF_N_INPUTS,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int STREAM_LEN = DEF_STREAM_LEN,
  parameter int NB_SUM     = clog2(N_INPUTS + 1),
  parameter int NB_ACC     = clog2(N_INPUTS * STREAM_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [N_REQ-1:0]          valid_i,
  input  logic [N_REQ*N_INPUTS-1:0] in_bus_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [N_REQ*NB_ACC-1:0]   sum_out_o
);

  localparam int SLOT_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int RND_W  = (STREAM_LEN > 1) ? clog2(STREAM_LEN) : 1;
  localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(N_REQ - 1);
  localparam logic [RND_W-1:0]  C_LAST_RND  = RND_W'(STREAM_LEN - 1);

  state_e                    state_q;
  logic [SLOT_W-1:0]         slot_q;
  logic [RND_W-1:0]          round_q;
  logic [NB_SUM-1:0]         p_sum_q;
  logic [SLOT_W-1:0]         p_slot_q;
  logic                      p_v_q;
  logic                      busy_q;
  logic                      done_q;
  logic [NB_ACC-1:0]         acc_q [N_REQ];
  logic [N_REQ*NB_ACC-1:0]   sum_out_q;

  logic                      w_consume;
  logic                      w_start_go;
  logic                      w_acc_en;
  logic [N_INPUTS-1:0]       w_slice;
  logic [NB_SUM-1:0]         w_pop;
  logic [N_REQ-1:0]          w_ack;

  // An ABORT cycle never consumes, so the requester is not acknowledged.
  assign w_consume  = (state_q == ST_RUN) && !abort_i && valid_i[slot_q];
  assign w_start_go = (state_q == ST_IDLE) && start_i && !abort_i;
  // The popcount in flight when ABORT hits is dropped rather than accumulated.
  assign w_acc_en   = p_v_q && (state_q != ST_IDLE) && !abort_i;
  assign w_slice    = in_bus_i[slot_q*N_INPUTS +: N_INPUTS];

  snn_sideadd_sched_adder #(
    .N_INPUTS (N_INPUTS),
    .NB_OUT   (NB_SUM)
  ) u_adder (
    .en_i  (w_consume),
    .in_i  (w_slice),
    .out_o (w_pop)
  );

  // Acknowledge only the requester whose TDM slot is active and consumed.
  always_comb begin
    w_ack = '0;
    if (w_consume) begin
      w_ack[slot_q] = 1'b1;
    end
  end

  assign ack_o     = w_ack;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sum_out_o = sum_out_q;

  // Control FSM: slot/round counters, popcount pipeline register, BUSY/DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      round_q  <= '0;
      p_sum_q  <= '0;
      p_slot_q <= '0;
      p_v_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          p_v_q <= 1'b0;
          if (w_start_go) begin
            slot_q  <= '0;
            round_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            p_v_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            p_v_q <= w_consume;
            if (w_consume) begin
              p_sum_q  <= w_pop;
              p_slot_q <= slot_q;
              if (slot_q == C_LAST_SLOT) begin
                slot_q <= '0;
                if (round_q == C_LAST_RND) begin
                  round_q <= '0;
                  state_q <= ST_DRAIN;
                end else begin
                  round_q <= round_q + 1'b1;
                end
              end else begin
                slot_q <= slot_q + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          p_v_q  <= 1'b0;
          busy_q <= 1'b0;
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          p_v_q   <= 1'b0;
          done_q  <= !abort_i;
          state_q <= ST_IDLE;
        end
        default: begin
          p_v_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Accumulator bank: cleared on an accepted START, one add per pipelined popcount.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REQ; r++) begin
        acc_q[r] <= '0;
      end
    end else if (w_start_go) begin
      for (int r = 0; r < N_REQ; r++) begin
        acc_q[r] <= '0;
      end
    end else if (w_acc_en) begin
      acc_q[p_slot_q] <= acc_q[p_slot_q] + NB_ACC'(p_sum_q);
    end
  end

  // Publish the finished window; held until the next completed window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_out_q <= '0;
    end else if ((state_q == ST_FIN) && !abort_i) begin
      for (int r = 0; r < N_REQ; r++) begin
        sum_out_q[r*NB_ACC +: NB_ACC] <= acc_q[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_sideadd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_sideadd_sched
//  Description : Self-checking bench for snn_sideadd_sched: a small instance
//                (4-bit slices, 2 requesters, 4 rounds) under directed and
//                random traffic, plus a default-parameter saturation window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_sideadd_sched;
  import snn_sideadd_sched_pkg::*;

  localparam int NI  = 4;
  localparam int NR  = 2;
  localparam int SL  = 4;
  localparam int NBA = clog2(NI * SL + 1);
  localparam int BW  = NI * NR;

  localparam int BNI  = 8;
  localparam int BNR  = 4;
  localparam int BSL  = 256;
  localparam int BNBA = clog2(BNI * BSL + 1);

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic [NR-1:0]   valid;
  logic [BW-1:0]   in_bus;
  logic [NR-1:0]   ack;
  logic            busy;
  logic            done;
  logic [NR*NBA-1:0] sum_out;

  logic              b_start;
  logic              b_abort;
  logic [BNR-1:0]    b_valid;
  logic [BNR*BNI-1:0] b_in_bus;
  logic [BNR-1:0]    b_ack;
  logic              b_busy;
  logic              b_done;
  logic [BNR*BNBA-1:0] b_sum_out;

  int n_cmp;
  int n_bad;
  int exp_sum  [NR];
  int last_sum [NR];

  snn_sideadd_sched #(
    .N_INPUTS   (NI),
    .N_REQ      (NR),
    .STREAM_LEN (SL)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .abort_i   (abort),
    .valid_i   (valid),
    .in_bus_i  (in_bus),
    .ack_o     (ack),
    .busy_o    (busy),
    .done_o    (done),
    .sum_out_o (sum_out)
  );

  snn_sideadd_sched dut_big (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (b_start),
    .abort_i   (b_abort),
    .valid_i   (b_valid),
    .in_bus_i  (b_in_bus),
    .ack_o     (b_ack),
    .busy_o    (b_busy),
    .done_o    (b_done),
    .sum_out_o (b_sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete window. The model walks the fixed turn order (slot = turn mod NR)
  // and only advances a turn when that turn's requester is valid.
  task automatic run_window(input bit rnd, input int stall_pct, input int stall_turn,
                            input int stall_len, input bit hold_start);
    int turn, stalls, sl, sidx, ecount, done_at, n_done;
    logic [NR-1:0] v;
    logic [NR-1:0] exp_ack;
    logic [BW-1:0] bus;
    for (int r = 0; r < NR; r++) exp_sum[r] = 0;
    turn = 0; stalls = 0; sidx = 0; ecount = 0; done_at = -1; n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    while (turn < NR * SL && ecount < 2000) begin
      sl = turn % NR;
      if (rnd) begin
        bus = BW'($urandom);
        v   = NR'($urandom);
        v[sl] = ($urandom_range(99) >= stall_pct);
      end else begin
        bus = 8'b0101_1111;
        v   = '1;
        if (turn == stall_turn && sidx < stall_len) begin
          v[sl] = 1'b0;
          sidx++;
        end
      end
      valid = v; in_bus = bus;
      #1;
      exp_ack = '0;
      if (v[sl]) exp_ack[sl] = 1'b1;
      check("ack_run", ack, exp_ack);
      check("busy_run", busy, 1);
      if (v[sl]) begin
        exp_sum[sl] += $countones(bus[sl*NI +: NI]);
        turn++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      ecount++;
    end
    check("window_turns", turn, NR * SL);
    for (int k = 1; k <= 6; k++) begin
      valid = NR'($urandom);
      #1;
      check("ack_tail", ack, 0);
      @(posedge clk); #1;
      ecount++;
      if (hold_start && k == 1) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = ecount;
          for (int r = 0; r < NR; r++)
            check("sum_out", sum_out[r*NBA +: NBA], exp_sum[r]);
          check("busy_at_done", busy, 0);
        end
      end
    end
    check("done_latency", done_at, NR * SL + stalls + 2);
    check("done_pulses", n_done, 1);
    check("busy_after", busy, 0);
    for (int r = 0; r < NR; r++) last_sum[r] = exp_sum[r];
  endtask

  initial begin
    int n_done, ecount, done_at;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = '0; in_bus = '0;
    b_start = 1'b0; b_abort = 1'b0; b_valid = '0; b_in_bus = '0;
    for (int r = 0; r < NR; r++) last_sum[r] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    valid = '1; b_valid = '1;
    #1;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_sum", sum_out, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_b_sum", b_sum_out, 0);
    b_valid = '0;
    @(posedge clk); #1;

    // Directed: slice0 = 1111, slice1 = 0101, never stalled.
    run_window(1'b0, 0, -1, 0, 1'b0);
    check("plan1_sum0", sum_out[0 +: NBA], 16);
    check("plan1_sum1", sum_out[NBA +: NBA], 8);

    // Directed: requester 1 withheld for 3 cycles in round 1.
    run_window(1'b0, 0, 3, 3, 1'b0);
    check("plan2_sum0", sum_out[0 +: NBA], 16);
    check("plan2_sum1", sum_out[NBA +: NBA], 8);

    // ABORT in the middle of a window.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      valid = '1; in_bus = BW'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b1; valid = '1;
    #1;
    check("ack_abort", ack, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("busy_abort", busy, 0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      valid = NR'($urandom);
      #1;
      check("ack_after_abort", ack, 0);
      if (done) n_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", n_done, 0);
    for (int r = 0; r < NR; r++)
      check("abort_sum_kept", sum_out[r*NBA +: NBA], last_sum[r]);

    run_window(1'b1, 30, -1, 0, 1'b0);

    // START held high through the whole window.
    run_window(1'b1, 0, -1, 0, 1'b1);

    // Asynchronous reset between edges while running.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      valid = '1; in_bus = BW'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    check("arst_ack", ack, 0);
    check("arst_sum", sum_out, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle_busy", busy, 0);
    run_window(1'b1, 20, -1, 0, 1'b0);

    for (int w = 0; w < 3; w++) begin
      run_window(1'b1, (w == 1) ? 50 : 0, -1, 0, 1'b0);
    end

    // Default parameters, all-ones slices: maximum count with no wrap.
    b_valid = '1; b_in_bus = '1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    ecount = 0; done_at = -1;
    while (done_at < 0 && ecount < BNR * BSL + 20) begin
      @(posedge clk); #1;
      ecount++;
      if (b_done) done_at = ecount;
    end
    check("big_latency", done_at, BNR * BSL + 2);
    for (int r = 0; r < BNR; r++)
      check("big_sum", b_sum_out[r*BNBA +: BNBA], 2048);
    b_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
